// File: rtl/sd_sampler_gen.sv
// Serial-data sampler: latches one of CHANNELS words on START and shifts it out on DATA, one bit per Y2 strobe.
// Optional odd-parity bit appended as the last bit time when SD_SAMPLER_PARITY_EN is defined.
module sd_sampler_gen #(
  parameter int CHANNELS  = 14,
  parameter int WIDTH     = 26,
  parameter bit LSB_FIRST = 1'b0,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      SIM_CLK,
  input  logic                      SIM_RST,
  input  logic                      START,
  input  logic [CW-1:0]             CHAN,
  input  logic [CHANNELS*WIDTH-1:0] CHAN_DATA,
  input  logic [CHANNELS-1:0]       CHAN_VALID,
  input  logic                      Y2,
  input  logic                      X2,
  output logic                      DATA,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      ERR
);

`ifdef SD_SAMPLER_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam int BW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FIN} state_t;

  state_t          state_q, state_d;
  logic [FL-1:0]   shreg_q, shreg_d;
  logic [BW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [WIDTH-1:0] sel_word;
  logic             sel_valid;
  logic [FL-1:0]    load_word;

  // Out-of-range channel addresses match no k and so read as invalid.
  always_comb begin
    sel_word  = '0;
    sel_valid = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (32'(CHAN) == k) begin
        sel_word  = CHAN_DATA[k*WIDTH +: WIDTH];
        sel_valid = CHAN_VALID[k];
      end
    end
  end

`ifdef SD_SAMPLER_PARITY_EN
  // Parity sits at the end opposite the first-shifted bit, so it always goes out last.
  assign load_word = LSB_FIRST ? {~^sel_word, sel_word} : {sel_word, ~^sel_word};
`else
  assign load_word = sel_word;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    if (X2) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_SHIFT: begin
          if (START) err_d = 1'b1;
          if (Y2) begin
            shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
            cnt_d   = cnt_q - BW'(1);
            if (cnt_q == BW'(1)) state_d = S_FIN;
          end
        end
        default: begin
          state_d = S_IDLE;
          if (START) begin
            if (sel_valid) begin
              shreg_d = load_word;
              cnt_d   = BW'(FL);
              state_d = S_SHIFT;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign DATA = (state_q == S_SHIFT) & (LSB_FIRST ? shreg_q[0] : shreg_q[FL-1]);
  assign BUSY = (state_q == S_SHIFT);
  assign DONE = (state_q == S_FIN);
  assign ERR  = err_q;

endmodule

// File: tb/tb_sd_sampler_gen.sv
// Bench for sd_sampler_gen (CHANNELS=4, WIDTH=8, MSB first); expected {DATA,BUSY,DONE,ERR} queued at drive time, compared one cycle later.
module tb_sd_sampler_gen;
  localparam int CH = 4;
  localparam int W  = 8;
`ifdef SD_SAMPLER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic          clk = 1'b0;
  logic          rst_n, start, y2, x2;
  logic [1:0]    chan;
  logic [CH*W-1:0] cdata;
  logic [CH-1:0] cvalid;
  logic          data_o, busy_o, done_o, err_o;

  always #5 clk = ~clk;

  sd_sampler_gen #(.CHANNELS(CH), .WIDTH(W), .LSB_FIRST(1'b0)) dut (
    .SIM_CLK(clk), .SIM_RST(rst_n), .START(start), .CHAN(chan),
    .CHAN_DATA(cdata), .CHAN_VALID(cvalid), .Y2(y2), .X2(x2),
    .DATA(data_o), .BUSY(busy_o), .DONE(done_o), .ERR(err_o)
  );

  typedef struct {
    logic       rst;
    logic       start;
    logic [1:0] chan;
    logic [3:0] valid;
    logic       y2;
    logic       x2;
    logic [3:0] exp;
  } vec_t;

  typedef struct {
    logic [3:0] exp;
    int         tag;
  } sb_t;

  vec_t tbl[15];
  sb_t  sbq[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic check_out();
    sb_t        t;
    logic [3:0] got;
    if (sbq.size() > 0) begin
      t   = sbq.pop_front();
      got = {data_o, busy_o, done_o, err_o};
      checks++;
      if (got !== t.exp) begin
        fails++;
        $display("FAIL step%0d {DATA,BUSY,DONE,ERR} got %b expected %b", t.tag, got, t.exp);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_out();
  endtask

  task automatic drive(input logic r, input logic s, input logic [1:0] c, input logic y,
                       input logic x, input logic [3:0] e, input int tag);
    rst_n = r; start = s; chan = c; y2 = y; x2 = x;
    sbq.push_back('{e, tag});
  endtask

  task automatic cyc(input logic r, input logic s, input logic [1:0] c, input logic y,
                     input logic x, input logic [3:0] e, input int tag);
    tick();
    drive(r, s, c, y, x, e, tag);
  endtask

  function automatic logic [FL-1:0] frame_bits(input logic [7:0] w);
`ifdef SD_SAMPLER_PARITY_EN
    return {w, ~^w};
`else
    return w;
`endif
  endfunction

  // START on channel c with word w, then FL Y2 strobes 'gap' cycles apart; ends with DUT in FIN.
  task automatic frame(input logic [1:0] c, input logic [7:0] w, input int gap,
                       input logic y2_with_start, input int tag);
    logic [FL-1:0] b;
    b = frame_bits(w);
    tick();
    cdata[c*W +: W] = w;
    cvalid[c] = 1'b1;
    drive(1'b1, 1'b1, c, y2_with_start, 1'b0, {b[FL-1], 3'b100}, tag);
    for (int i = 0; i < FL; i++) begin
      for (int j = 0; j < gap; j++) begin
        tick();
        if (i == 0 && j == 0) cdata[c*W +: W] = ~w;
        if (j < gap - 1)
          drive(1'b1, 1'b0, c, 1'b0, 1'b0, {b[FL-1-i], 3'b100}, tag + i);
        else if (i == FL - 1)
          drive(1'b1, 1'b0, c, 1'b1, 1'b0, 4'b0010, tag + i);
        else
          drive(1'b1, 1'b0, c, 1'b1, 1'b0, {b[FL-2-i], 3'b100}, tag + i);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; chan = 2'd0; y2 = 1'b0; x2 = 1'b0;
    cdata  = {8'hFF, 8'hA5, 8'h33, 8'h01};
    cvalid = 4'b0100;

    //        rst   start chan  valid    y2    x2    {DATA,BUSY,DONE,ERR}
    tbl[0]  = '{1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0, 4'b0000};
    tbl[1]  = '{1'b0, 1'b1, 2'd2, 4'b0100, 1'b0, 1'b0, 4'b0000};
    tbl[2]  = '{1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 1'b0, 4'b0000};
    tbl[3]  = '{1'b1, 1'b1, 2'd1, 4'b0100, 1'b0, 1'b0, 4'b0001};
    tbl[4]  = '{1'b1, 1'b0, 2'd1, 4'b0100, 1'b0, 1'b0, 4'b0000};
    tbl[5]  = '{1'b1, 1'b1, 2'd3, 4'b0100, 1'b0, 1'b0, 4'b0001};
    tbl[6]  = '{1'b1, 1'b1, 2'd2, 4'b0100, 1'b0, 1'b1, 4'b0000};
    tbl[7]  = '{1'b1, 1'b0, 2'd2, 4'b0100, 1'b0, 1'b0, 4'b0000};
    tbl[8]  = '{1'b1, 1'b1, 2'd2, 4'b0100, 1'b0, 1'b0, 4'b1100};
    tbl[9]  = '{1'b1, 1'b0, 2'd2, 4'b0100, 1'b0, 1'b0, 4'b1100};
    tbl[10] = '{1'b1, 1'b1, 2'd2, 4'b0100, 1'b0, 1'b0, 4'b1101};
    tbl[11] = '{1'b1, 1'b0, 2'd2, 4'b0100, 1'b0, 1'b0, 4'b1100};
    tbl[12] = '{1'b1, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0, 4'b0100};
    tbl[13] = '{1'b1, 1'b0, 2'd2, 4'b0100, 1'b0, 1'b1, 4'b0000};
    tbl[14] = '{1'b1, 1'b0, 2'd2, 4'b0100, 1'b0, 1'b0, 4'b0000};

    for (int i = 0; i < 15; i++) begin
      tick();
      cvalid = tbl[i].valid;
      drive(tbl[i].rst, tbl[i].start, tbl[i].chan, tbl[i].y2, tbl[i].x2, tbl[i].exp, i);
    end

    // Full frame, strobes 3 cycles apart; DONE exactly once
    frame(2'd2, 8'hA5, 3, 1'b0, 100);
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 150);

    // START+Y2 together in IDLE, then back-to-back START in FIN
    frame(2'd1, 8'h33, 1, 1'b1, 200);
    frame(2'd0, 8'h01, 2, 1'b0, 300);
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 350);

    frame(2'd2, 8'h07, 1, 1'b0, 400);
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 450);

    // Abort an 8'hFF frame after the third strobe
    tick();
    cdata[31:24] = 8'hFF;
    cvalid[3] = 1'b1;
    drive(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 4'b1100, 500);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 4'b1100, 501 + i);
    cyc(1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 4'b0000, 504);
    cyc(1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 4'b0000, 505);
    cyc(1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 4'b0000, 506);
    cyc(1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 4'b0000, 507);

    // Reset in mid-frame
    tick();
    cdata[23:16] = 8'hA5;
    drive(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 4'b1100, 600);
    cyc(1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 4'b0100, 601);
    cyc(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0000, 602);
    cyc(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 4'b0000, 603);
    cyc(1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 4'b0000, 604);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sd_sampler_gen.md
Name: sd_sampler_gen

Overview:
- Parametrised serial-data sampler for the LVDA telemetry path.
- Selects one of CHANNELS parallel words by channel address and validity, latches the word on a start command, and shifts it out on DATA one bit per Y2 bit-time strobe.
- X2 acts as the word-boundary clear.
- Generalises the fixed-gate discrete sampler: arbitrary channel count and width, held frame, completion/error status, optional parity.

Parameters:
- CHANNELS, 14, number of selectable input words (must be >= 1).
- WIDTH, 26, bits per word (LVDC word length); must be >= 1.
- LSB_FIRST, 0, 0 = shift MSB first, 1 = shift LSB first.
- Derived localparam CW = max(1, clog2(CHANNELS)); BW = clog2(WIDTH+2), bit-counter width.

Ports:
- SIM_CLK  in  1  single system clock; all logic on rising edge.
- SIM_RST  in  1  synchronous, active-low reset.
- START  in  1  one-cycle request to sample and send a word.
- CHAN  in  CW  channel address, sampled with START.
- CHAN_DATA  in  CHANNELS*WIDTH  packed words; channel k at bits [k*WIDTH +: WIDTH].
- CHAN_VALID  in  CHANNELS  per-channel data-available flags (MLAV-style).
- Y2  in  1  bit-time strobe; advances the shifter.
- X2  in  1  clear/abort; returns to idle.
- DATA  out  1  serial output bit.
- BUSY  out  1  high while a frame is being shifted.
- DONE  out  1  one-cycle pulse after the final bit time.
- ERR  out  1  one-cycle pulse on a rejected START.

Behaviour:
- States: IDLE, SHIFT, FIN. Registers: state, shreg[WIDTH] (+1 with parity), bit counter cnt.
- Reset (SIM_RST=0 at clock edge):
  - state=IDLE, shreg=0, cnt=0.
  - DATA=0, BUSY=0, DONE=0, ERR=0.
  - Reset overrides every other input, mid-frame included.
- Outputs are registered or decoded from state; no combinational path from inputs to outputs.
- IDLE:
  - DATA=0, BUSY=0.
  - START with CHAN<CHANNELS and CHAN_VALID[CHAN]=1: shreg <= CHAN_DATA word, cnt <= frame length (WIDTH, or WIDTH+1 with parity), next state SHIFT.
  - START with CHAN>=CHANNELS or CHAN_VALID[CHAN]=0: ERR=1 next cycle, stay IDLE.
  - Y2 alone in IDLE is ignored.
- SHIFT:
  - BUSY=1; DATA = shreg MSB (LSB if LSB_FIRST).
  - The first bit appears the cycle after START acceptance.
  - Each Y2 shifts shreg one place (zero fill) and decrements cnt.
  - Y2 with cnt==1 moves to FIN.
  - Without Y2, the current bit is held indefinitely.
- FIN: one cycle; DONE=1, BUSY=0, DATA=0, then IDLE.
  - A valid START in FIN is accepted as in IDLE: loads and goes straight to SHIFT (back-to-back frames, no idle gap).
- START while in SHIFT: ignored; ERR=1 for one cycle; frame continues unaffected.
- Same-cycle priority: SIM_RST > X2 > START > Y2.
  - X2 in any state: state=IDLE, DATA=0, cnt=0, no DONE pulse, START in the same cycle discarded without ERR.
  - START and Y2 together in IDLE/FIN: START accepted, Y2 not counted.
- Data sampling: CHAN_DATA is read only in the START acceptance cycle; later changes do not affect the frame.

Optional Feature:
- Macro SD_SAMPLER_PARITY_EN.
- Defined:
  - On load, an odd-parity bit is computed over the WIDTH data bits (bit = ~^word) and appended as the final bit time.
  - Frame is WIDTH+1 Y2 strobes; shreg is WIDTH+1 wide.
- Undefined: no parity logic; frame is exactly WIDTH Y2 strobes.

Test Plan:
- Bench uses CHANNELS=4, WIDTH=8, LSB_FIRST=0.
- Reset: hold SIM_RST=0 two cycles with START=1, Y2 toggling -> DATA=BUSY=DONE=ERR=0; release, state IDLE.
- Basic frame: CHAN_DATA ch2=8'hA5, CHAN_VALID=4'b0100, START with CHAN=2, then 8 Y2 strobes 3 cycles apart -> DATA sequence 1,0,1,0,0,1,0,1; BUSY high throughout; DONE pulses once, one cycle after the 8th Y2.
- Rejects:
  - START CHAN=1 with CHAN_VALID[1]=0 -> ERR one-cycle pulse, BUSY stays 0.
  - START mid-frame -> ERR pulse, frame bits unchanged.
- Abort: X2 after 3rd Y2 of 8'hFF frame -> DATA=0, BUSY=0 next cycle, no DONE. START+X2 same cycle -> no frame, no ERR.
- Back-to-back: START ch0=8'h01 in the FIN cycle of the previous frame -> DONE and new BUSY in consecutive cycles; second frame outputs 0,0,0,0,0,0,0,1.
- Parity (SD_SAMPLER_PARITY_EN defined):
  - 8'hA5 -> 9th bit 1.
  - 8'h07 -> 9th bit 0.
  - DONE only after the 9th Y2.
